// File: rtl/retire_track_pipe.sv
// Carries retire validity and counter-CSR select from ID through EX/MEM/WB,
// advancing exactly like the core's pipeline registers.
module retire_track_pipe #(
    parameter bit NOP_FILTER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IM_stall,
    input  logic        DM_stall,
    input  logic        hazard_stall,
    input  logic        flush,
    input  logic        D_valid,
    input  logic [4:0]  D_opcode,
    input  logic [2:0]  D_funct3,
    input  logic [4:0]  D_rs1_index,
    input  logic [4:0]  D_rd_index,
    input  logic [11:0] D_csr_addr,
    output logic        W_valid_inst,
    output logic [1:0]  W_imm,
    output logic        W_csr_read,
    output logic        W_csr_illegal
);

    typedef struct packed {
        logic       valid;
        logic [1:0] sel;
        logic       csr_read;
        logic       illegal;
    } stage_t;

    stage_t     w_id;
    stage_t     r_ex;
    stage_t     r_mem;
    stage_t     r_wb;

    logic       w_is_nop;
    logic       w_retire;
    logic       w_csr_access;
    logic       w_addr_hit;
    logic       w_counter_rd;
    logic [1:0] w_sel;
    logic       w_global_stall;
    logic       w_bubble_ex;

    always_comb begin
        w_addr_hit = 1'b1;
        w_sel      = 2'b00;
        case (D_csr_addr)
            12'hC00: w_sel = 2'b00;
            12'hC80: w_sel = 2'b10;
            12'hC02: w_sel = 2'b01;
            12'hC82: w_sel = 2'b11;
            default: w_addr_hit = 1'b0;
        endcase

        w_is_nop = NOP_FILTER && (D_opcode == 5'b00100) && (D_funct3 == 3'b000)
                   && (D_rs1_index == 5'd0) && (D_rd_index == 5'd0);
        w_retire = D_valid && !w_is_nop;

        w_csr_access = (D_opcode == 5'b11100) && (D_funct3 != 3'b000);
        // Only csrrs with rs1=x0 is a pure read; anything else touching a CSR is unsupported.
        w_counter_rd = w_csr_access && (D_funct3 == 3'b010) && (D_rs1_index == 5'd0)
                       && w_addr_hit;

        w_id.valid    = w_retire;
        w_id.csr_read = w_retire && w_counter_rd;
        w_id.sel      = (w_retire && w_counter_rd) ? w_sel : 2'b00;
        w_id.illegal  = w_retire && w_csr_access && !w_counter_rd;
    end

    assign w_global_stall = IM_stall || DM_stall;
    assign w_bubble_ex    = flush || hazard_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!w_global_stall) begin
            r_ex  <= w_bubble_ex ? stage_t'('0) : w_id;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    assign W_valid_inst  = r_wb.valid;
    assign W_imm         = r_wb.sel;
    assign W_csr_read    = r_wb.csr_read;
    assign W_csr_illegal = r_wb.illegal;

endmodule

// File: tb/tb_retire_track_pipe.sv
// Bench for retire_track_pipe: directed scenarios plus a randomized run
// against a queue-based reference model, on NOP-filtering and non-filtering instances.
module tb_retire_track_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        IM_stall = 1'b0;
    logic        DM_stall = 1'b0;
    logic        hazard_stall = 1'b0;
    logic        flush = 1'b0;
    logic        D_valid = 1'b0;
    logic [4:0]  D_opcode = '0;
    logic [2:0]  D_funct3 = '0;
    logic [4:0]  D_rs1_index = '0;
    logic [4:0]  D_rd_index = '0;
    logic [11:0] D_csr_addr = '0;

    logic        a_valid, b_valid;
    logic [1:0]  a_imm, b_imm;
    logic        a_rd, b_rd;
    logic        a_ill, b_ill;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    retire_track_pipe #(.NOP_FILTER(1'b1)) dut_a (
        .clk(clk), .rst(rst), .IM_stall(IM_stall), .DM_stall(DM_stall),
        .hazard_stall(hazard_stall), .flush(flush), .D_valid(D_valid),
        .D_opcode(D_opcode), .D_funct3(D_funct3), .D_rs1_index(D_rs1_index),
        .D_rd_index(D_rd_index), .D_csr_addr(D_csr_addr),
        .W_valid_inst(a_valid), .W_imm(a_imm), .W_csr_read(a_rd), .W_csr_illegal(a_ill)
    );

    retire_track_pipe #(.NOP_FILTER(1'b0)) dut_b (
        .clk(clk), .rst(rst), .IM_stall(IM_stall), .DM_stall(DM_stall),
        .hazard_stall(hazard_stall), .flush(flush), .D_valid(D_valid),
        .D_opcode(D_opcode), .D_funct3(D_funct3), .D_rs1_index(D_rs1_index),
        .D_rd_index(D_rd_index), .D_csr_addr(D_csr_addr),
        .W_valid_inst(b_valid), .W_imm(b_imm), .W_csr_read(b_rd), .W_csr_illegal(b_ill)
    );

    task automatic put(input logic v, input logic [4:0] op, input logic [2:0] f3,
                       input logic [4:0] r1, input logic [4:0] rdi, input logic [11:0] ca);
        D_valid = v; D_opcode = op; D_funct3 = f3;
        D_rs1_index = r1; D_rd_index = rdi; D_csr_addr = ca;
    endtask

    task automatic put_alu();    put(1'b1, 5'b00100, 3'b000, 5'd1, 5'd2, 12'h001); endtask
    task automatic put_nop();    put(1'b1, 5'b00100, 3'b000, 5'd0, 5'd0, 12'h000); endtask
    task automatic put_bubble(); put(1'b0, 5'b00000, 3'b000, 5'd0, 5'd0, 12'h000); endtask
    task automatic put_csrrs(input logic [11:0] ca, input logic [4:0] rdi);
        put(1'b1, 5'b11100, 3'b010, 5'd0, rdi, ca);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        put_bubble();
        IM_stall = 1'b0; DM_stall = 1'b0; hazard_stall = 1'b0; flush = 1'b0;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        put_bubble();
        tick(); tick();
        n_checks++;
        if ({a_valid, a_imm, a_rd, a_ill} !== 5'b0)
            $display("FAIL reset_a got=%b want=00000", {a_valid, a_imm, a_rd, a_ill});
        else n_pass++;
        n_checks++;
        if ({b_valid, b_imm, b_rd, b_ill} !== 5'b0)
            $display("FAIL reset_b got=%b want=00000", {b_valid, b_imm, b_rd, b_ill});
        else n_pass++;
        rst = 1'b1;
    endtask

    // Cycle n: inputs presented during cycle n, outputs observed during cycle n.
    task automatic test_alu_stream();
        do_reset();
        for (int n = 0; n < 9; n++) begin
            if (n < 4) put_alu(); else put_bubble();
            n_checks++;
            if (a_valid !== ((n >= 3) && (n <= 6)))
                $display("FAIL alu_valid cyc=%0d got=%b want=%b", n, a_valid, (n >= 3) && (n <= 6));
            else n_pass++;
            n_checks++;
            if (a_imm !== 2'b00)
                $display("FAIL alu_imm cyc=%0d got=%b want=00", n, a_imm);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_csr_read();
        do_reset();
        for (int n = 0; n < 6; n++) begin
            if (n == 0) put_csrrs(12'hC82, 5'd5);
            else if (n == 1) put_csrrs(12'hC00, 5'd6);
            else put_bubble();
            if (n == 3) begin
                n_checks++;
                if ({a_valid, a_rd, a_imm, a_ill} !== 5'b11110)
                    $display("FAIL csr_instreth got=%b want=11110", {a_valid, a_rd, a_imm, a_ill});
                else n_pass++;
            end
            if (n == 4) begin
                n_checks++;
                if ({a_valid, a_rd, a_imm, a_ill} !== 5'b11000)
                    $display("FAIL csr_cycle got=%b want=11000", {a_valid, a_rd, a_imm, a_ill});
                else n_pass++;
            end
            if (n == 5) begin
                n_checks++;
                if (a_valid !== 1'b0)
                    $display("FAIL csr_tail got=%b want=0", a_valid);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_nop_filter();
        do_reset();
        for (int n = 0; n < 6; n++) begin
            if (n == 0 || n == 2) put_alu();
            else if (n == 1) put_nop();
            else put_bubble();
            if (n >= 3) begin
                n_checks++;
                if (a_valid !== (n != 4))
                    $display("FAIL nop_filt cyc=%0d got=%b want=%b", n, a_valid, n != 4);
                else n_pass++;
                n_checks++;
                if (b_valid !== 1'b1)
                    $display("FAIL nop_nofilt cyc=%0d got=%b want=1", n, b_valid);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_dm_stall();
        logic [2:0] want;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            if (n == 0) put_csrrs(12'hC82, 5'd7);
            else if (n == 1) put_alu();
            else put_bubble();
            DM_stall = (n >= 3) && (n <= 5);
            if (n >= 3 && n <= 6)      want = 3'b111;
            else if (n == 7)           want = 3'b100;
            else                       want = 3'b000;
            n_checks++;
            if ({a_valid, a_rd, a_imm[1]} !== want)
                $display("FAIL dm_stall cyc=%0d got=%b want=%b", n, {a_valid, a_rd, a_imm[1]}, want);
            else n_pass++;
            tick();
        end
        DM_stall = 1'b0;
    endtask

    task automatic test_flush_hazard();
        do_reset();
        for (int n = 0; n < 8; n++) begin
            if (n <= 2) put_alu(); else put_bubble();
            flush        = (n == 1);
            hazard_stall = (n == 1);
            if (n >= 2) begin
                n_checks++;
                if (a_valid !== ((n == 3) || (n == 5)))
                    $display("FAIL flush cyc=%0d got=%b want=%b", n, a_valid, (n == 3) || (n == 5));
                else n_pass++;
            end
            tick();
        end
        flush = 1'b0; hazard_stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            if (n == 0) put(1'b1, 5'b11100, 3'b001, 5'd1, 5'd1, 12'h300);
            else put_alu();
            if (n == 3) begin
                n_checks++;
                if ({a_valid, a_rd, a_imm, a_ill} !== 5'b10001)
                    $display("FAIL illegal_csr got=%b want=10001", {a_valid, a_rd, a_imm, a_ill});
                else n_pass++;
            end
            if (n < 3) tick();
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({a_valid, a_imm, a_rd, a_ill, b_valid, b_imm, b_rd, b_ill} !== 10'b0)
            $display("FAIL rst_async got=%b want=0",
                     {a_valid, a_imm, a_rd, a_ill, b_valid, b_imm, b_rd, b_ill});
        else n_pass++;
        put_bubble();
        tick();
        rst = 1'b1;
        for (int n = 0; n < 5; n++) begin
            n_checks++;
            if ({a_valid, a_imm, a_rd, a_ill, b_valid, b_imm, b_rd, b_ill} !== 10'b0)
                $display("FAIL rst_drain cyc=%0d got=%b want=0", n,
                         {a_valid, a_imm, a_rd, a_ill, b_valid, b_imm, b_rd, b_ill});
            else n_pass++;
            tick();
        end
    endtask

    // Expected WB tuple {valid, sel, csr_read, illegal} for the instruction now in ID.
    function automatic logic [4:0] ref_decode(input bit filt);
        bit nop;
        bit is_counter;
        nop = filt && D_opcode == 5'd4 && D_funct3 == 3'd0 && D_rs1_index == 5'd0
              && D_rd_index == 5'd0;
        if (!D_valid || nop) return 5'b0;
        if (D_opcode != 5'b11100 || D_funct3 == 3'd0) return 5'b10000;
        is_counter = (D_csr_addr == 12'hC00) || (D_csr_addr == 12'hC80) ||
                     (D_csr_addr == 12'hC02) || (D_csr_addr == 12'hC82);
        if (D_funct3 == 3'd2 && D_rs1_index == 5'd0 && is_counter)
            return {1'b1, D_csr_addr[7], D_csr_addr[1], 1'b1, 1'b0};
        return 5'b10001;
    endfunction

    task automatic rand_inst();
        logic [11:0] addrs [0:5];
        int kind;
        addrs[0] = 12'hC00; addrs[1] = 12'hC80; addrs[2] = 12'hC02;
        addrs[3] = 12'hC82; addrs[4] = 12'h300; addrs[5] = 12'hC01;
        kind = $urandom_range(0, 5);
        D_valid     = ($urandom_range(0, 9) != 0);
        D_opcode    = 5'($urandom);
        D_funct3    = 3'($urandom);
        D_rs1_index = 5'($urandom);
        D_rd_index  = 5'($urandom);
        D_csr_addr  = 12'($urandom);
        case (kind)
            0: begin D_opcode = 5'b00100; D_funct3 = 3'b000; D_rs1_index = 5'd0; D_rd_index = 5'd0; end
            1: D_opcode = 5'b00100;
            2: begin
                D_opcode = 5'b11100; D_funct3 = 3'b010;
                D_rs1_index = ($urandom_range(0, 3) == 0) ? 5'd3 : 5'd0;
                D_csr_addr = addrs[$urandom_range(0, 3)];
            end
            3: begin D_opcode = 5'b11100; D_csr_addr = addrs[$urandom_range(0, 5)]; end
            4: begin D_opcode = 5'b11100; D_funct3 = 3'b000; end
            default: ;
        endcase
    endtask

    task automatic test_random();
        logic [4:0] qa [$];
        logic [4:0] qb [$];
        do_reset();
        qa = '{5'b0, 5'b0, 5'b0};
        qb = '{5'b0, 5'b0, 5'b0};
        for (int n = 0; n < 600; n++) begin
            rand_inst();
            IM_stall     = ($urandom_range(0, 7) == 0);
            DM_stall     = ($urandom_range(0, 7) == 0);
            hazard_stall = ($urandom_range(0, 5) == 0);
            flush        = ($urandom_range(0, 7) == 0);
            n_checks++;
            if ({a_valid, a_imm, a_rd, a_ill} !== qa[2])
                $display("FAIL rand_a cyc=%0d got=%b want=%b", n, {a_valid, a_imm, a_rd, a_ill}, qa[2]);
            else n_pass++;
            n_checks++;
            if ({b_valid, b_imm, b_rd, b_ill} !== qb[2])
                $display("FAIL rand_b cyc=%0d got=%b want=%b", n, {b_valid, b_imm, b_rd, b_ill}, qb[2]);
            else n_pass++;
            if (!(IM_stall || DM_stall)) begin
                qa.push_front((flush || hazard_stall) ? 5'b0 : ref_decode(1'b1));
                qb.push_front((flush || hazard_stall) ? 5'b0 : ref_decode(1'b0));
                void'(qa.pop_back());
                void'(qb.pop_back());
            end
            tick();
        end
        IM_stall = 1'b0; DM_stall = 1'b0; hazard_stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_stream();
        test_csr_read();
        test_nop_filter();
        test_dm_stall();
        test_flush_hazard();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
